tt_sweep_ctrl: RTL and testbench



---
 rtl/tt_sweep_pkg.sv | 19 +
 rtl/tt_sweep_ctrl_if.sv | 37 +++
 rtl/tt_popcount.sv | 24 ++
 rtl/tt_sweep_ctrl.sv | 166 ++++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and sizes for the truth-table sweep controller.
// Optional build macro used elsewhere in this slice: TT_STABILITY_CHECK_EN.
package tt_sweep_pkg;

  // Number of circuit inputs and the resulting truth-table width.
  localparam int N_IN   = 3;
  localparam int TT_W   = 1 << N_IN;
  // Vector index width, settle-counter width (covers 1..255), mismatch-count width (0..8).
  localparam int IDX_W  = N_IN;
  localparam int CNT_W  = 8;
  localparam int MCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_e;

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Bundle of the harness handshake and circuit-under-test signals of the sweep controller.
// The unstable flag exists only when TT_STABILITY_CHECK_EN is defined.
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;

  logic              start;
  logic [TT_W-1:0]   expected_tt;
  logic              dut_out;
  logic [N_IN-1:0]   dut_in;
  logic              busy;
  logic              done;
  logic [TT_W-1:0]   observed_tt;
  logic [MCNT_W-1:0] mismatch_cnt;
  logic              pass;
`ifdef TT_STABILITY_CHECK_EN
  logic              unstable;
`endif

  // Harness / stimulus side.
  modport master (
    output start, expected_tt, dut_out,
    input  dut_in, busy, done, observed_tt, mismatch_cnt, pass
`ifdef TT_STABILITY_CHECK_EN
    , input unstable
`endif
  );

  // Controller side.
  modport slave (
    input  start, expected_tt, dut_out,
    output dut_in, busy, done, observed_tt, mismatch_cnt, pass
`ifdef TT_STABILITY_CHECK_EN
    , output unstable
`endif
  );

endinterface

// File: rtl/tt_popcount.sv
// Combinational count of differing bits between two truth tables.
module tt_popcount
  import tt_sweep_pkg::*;
(
  input  logic [TT_W-1:0]   a_i,
  input  logic [TT_W-1:0]   b_i,
  output logic [MCNT_W-1:0] cnt_o
);

  logic [TT_W-1:0] diff;

  for (genvar gi = 0; gi < TT_W; gi++) begin : g_diff
    assign diff[gi] = a_i[gi] ^ b_i[gi];
  end

  // Sum the per-bit differences.
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < TT_W; i++) begin
      cnt_o = cnt_o + MCNT_W'(diff[i]);
    end
  end

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Truth-table sweep controller: walks all 8 input vectors through a 3-input circuit,
// holds each for SETTLE_CYCLES cycles, samples the circuit output on the last cycle,
// then reports the observed table, mismatch count against the expected table and pass.
// Optional macro TT_STABILITY_CHECK_EN adds a second-to-last-cycle sample and a sticky
// unstable flag that also forces pass low.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  tt_sweep_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(TT_W - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TT_W-1:0]   exp_q, exp_d;
  logic [TT_W-1:0]   obs_q, obs_d;
  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              pass_q, pass_d;

  // Observed table including the bit being sampled this cycle, and its mismatch count.
  logic [TT_W-1:0]   obs_sample;
  logic [MCNT_W-1:0] mcnt_sample;
  // Unstable status including this cycle's comparison (constant 0 without the feature).
  logic              unst_sample;

`ifdef TT_STABILITY_CHECK_EN
  // Only meaningful when a vector is held long enough to be sampled twice.
  localparam bit STAB_ON = (SETTLE_CYCLES >= 2);

  logic prev_q, prev_d;
  logic unst_q, unst_d;

  // Sticky instability: last-cycle sample differs from the second-to-last one.
  always_comb begin
    unst_sample = unst_q;
    if (STAB_ON && (state_q == SETTLE) && (cnt_q == '0) && (bus.dut_out != prev_q)) begin
      unst_sample = 1'b1;
    end
  end
`else
  assign unst_sample = 1'b0;
`endif

  // Merge the current circuit output into the table at the active vector index.
  always_comb begin
    obs_sample        = obs_q;
    obs_sample[idx_q] = bus.dut_out;
  end

  tt_popcount u_popcount (
    .a_i   (obs_sample),
    .b_i   (exp_q),
    .cnt_o (mcnt_sample)
  );

  // State register and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      obs_q   <= '0;
      mcnt_q  <= '0;
      pass_q  <= 1'b0;
`ifdef TT_STABILITY_CHECK_EN
      prev_q  <= 1'b0;
      unst_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      obs_q   <= obs_d;
      mcnt_q  <= mcnt_d;
      pass_q  <= pass_d;
`ifdef TT_STABILITY_CHECK_EN
      prev_q  <= prev_d;
      unst_q  <= unst_d;
`endif
    end
  end

  // Next-state logic: accept in IDLE, step vectors in SETTLE, one-cycle DONE.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    obs_d   = obs_q;
    mcnt_d  = mcnt_q;
    pass_d  = pass_q;
`ifdef TT_STABILITY_CHECK_EN
    prev_d  = prev_q;
    unst_d  = unst_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          exp_d   = bus.expected_tt;
          idx_d   = '0;
          cnt_d   = CNT_RELOAD;
          obs_d   = '0;
          mcnt_d  = '0;
          pass_d  = 1'b0;
`ifdef TT_STABILITY_CHECK_EN
          prev_d  = 1'b0;
          unst_d  = 1'b0;
`endif
          state_d = SETTLE;
        end
      end

      SETTLE: begin
`ifdef TT_STABILITY_CHECK_EN
        if (STAB_ON && (cnt_q == CNT_W'(1))) begin
          prev_d = bus.dut_out;
        end
        unst_d = unst_sample;
`endif
        if (cnt_q == '0) begin
          obs_d = obs_sample;
          if (idx_q == IDX_LAST) begin
            // Results become visible together with the done pulse.
            mcnt_d  = mcnt_sample;
            pass_d  = (mcnt_sample == '0) && !unst_sample;
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_RELOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.dut_in       = (state_q == SETTLE) ? idx_q : '0;
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.observed_tt  = obs_q;
  assign bus.mismatch_cnt = mcnt_q;
  assign bus.pass         = pass_q;
`ifdef TT_STABILITY_CHECK_EN
  assign bus.unstable     = unst_q;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Directed bench for tt_sweep_ctrl: two instances (SETTLE_CYCLES=4 and 1) driven by
// stub circuits, with hand-computed truth tables and latencies.
// Honours TT_STABILITY_CHECK_EN when defined.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  logic clk;
  logic rst;
  logic start_r;
  logic sel;            // 0: SETTLE_CYCLES=4 instance, 1: SETTLE_CYCLES=1 instance
  logic [1:0] mode;     // 0: out=in1, 1: out=~(in2|in3), 2: in1 with glitch on vector 3
  logic [7:0] exp_r;
  int   v3cnt;

  int n_cmp = 0;
  int n_bad = 0;

  tt_sweep_ctrl_if bus4();
  tt_sweep_ctrl_if bus1();

  tt_sweep_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
  tt_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic stub(input logic [2:0] v, input logic [1:0] m, input int c3);
    case (m)
      2'd0:    stub = v[2];
      2'd1:    stub = ~(v[1] | v[0]);
      2'd2:    stub = v[2] | ((v == 3'd3) && (c3 == 3));
      default: stub = 1'b0;
    endcase
  endfunction

  // Cycles spent on vector 3 by the 4-cycle instance; 3 marks its sampling cycle.
  always @(posedge clk) v3cnt <= (bus4.dut_in == 3'd3) ? v3cnt + 1 : 0;

  assign bus4.start       = start_r & ~sel;
  assign bus1.start       = start_r & sel;
  assign bus4.expected_tt = exp_r;
  assign bus1.expected_tt = exp_r;
  assign bus4.dut_out     = stub(bus4.dut_in, mode, v3cnt);
  assign bus1.dut_out     = stub(bus1.dut_in, mode, 0);

  logic [2:0] m_dut_in;
  logic       m_busy, m_done, m_pass;
  logic [7:0] m_obs;
  logic [3:0] m_mcnt;
  assign m_dut_in = sel ? bus1.dut_in       : bus4.dut_in;
  assign m_busy   = sel ? bus1.busy         : bus4.busy;
  assign m_done   = sel ? bus1.done         : bus4.done;
  assign m_pass   = sel ? bus1.pass         : bus4.pass;
  assign m_obs    = sel ? bus1.observed_tt  : bus4.observed_tt;
  assign m_mcnt   = sel ? bus1.mismatch_cnt : bus4.mismatch_cnt;
`ifdef TT_STABILITY_CHECK_EN
  logic m_unst;
  assign m_unst = sel ? bus1.unstable : bus4.unstable;
`endif

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Raise start for one cycle; returns #1 into the first cycle after acceptance.
  task automatic accept();
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
  endtask

  // Follow a sweep from cycle 1 to the done cycle, checking vector order and latency.
  // With ign set, start is pulsed at cycle 5 and in the done cycle.
  task automatic follow(input int s, input bit ign);
    int k;
    int dc;
    k  = 1;
    dc = -1;
    while (k <= 8 * s + 6) begin
      start_r = ign && ((k == 5) || (k == 1 + 8 * s));
      if (m_done) begin
        dc = k;
        break;
      end
      check($sformatf("dut_in@%0d", k), 32'(m_dut_in), 32'((k - 1) / s));
      check($sformatf("busy@%0d", k), 32'(m_busy), 32'd1);
      @(posedge clk); #1;
      k++;
    end
    check("done_latency", 32'(dc), 32'(1 + 8 * s));
    check("busy_at_done", 32'(m_busy), 32'd1);
  endtask

  task automatic check_results(input logic [7:0] obs, input logic [3:0] mc,
                               input logic ps, input logic un);
    check("observed_tt", 32'(m_obs), 32'(obs));
    check("mismatch_cnt", 32'(m_mcnt), 32'(mc));
    check("pass", 32'(m_pass), 32'(ps));
`ifdef TT_STABILITY_CHECK_EN
    check("unstable", 32'(m_unst), 32'(un));
`else
    if (un) check("unstable_unsupported", 32'd1, 32'(un));
`endif
    $display("sweep sel=%0d mode=%0d exp=0x%02h -> obs=0x%02h mcnt=%0d pass=%0d",
             sel, mode, exp_r, m_obs, m_mcnt, m_pass);
  endtask

  // One cycle after done: back in IDLE with results held.
  task automatic post_done(input logic [7:0] obs);
    @(posedge clk); #1;
    start_r = 1'b0;
    check("done_pulse_len", 32'(m_done), 32'd0);
    check("idle_busy", 32'(m_busy), 32'd0);
    check("idle_dut_in", 32'(m_dut_in), 32'd0);
    check("held_observed", 32'(m_obs), 32'(obs));
  endtask

  task automatic sweep(input logic s_sel, input logic [1:0] m, input logic [7:0] e,
                       input logic [7:0] obs, input logic [3:0] mc, input logic ps,
                       input logic un);
    sel   = s_sel;
    mode  = m;
    exp_r = e;
    @(posedge clk); #1;
    accept();
    follow(s_sel ? 1 : 4, 1'b0);
    check_results(obs, mc, ps, un);
    post_done(obs);
  endtask

  initial begin
    int saw;
    rst = 1'b1; start_r = 1'b0; sel = 1'b0; mode = 2'd0; exp_r = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dut_in", 32'(bus4.dut_in), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_observed", 32'(bus4.observed_tt), 32'd0);
    check("rst_mcnt", 32'(bus4.mismatch_cnt), 32'd0);
    check("rst_pass", 32'(bus4.pass), 32'd0);
    rst = 1'b0;

    // out=in1 against 0xF0: exact match.
    sweep(1'b0, 2'd0, 8'hF0, 8'hF0, 4'd0, 1'b1, 1'b0);
    // out=~(in2|in3): ones at vectors 0 and 4.
    sweep(1'b0, 2'd1, 8'h00, 8'h11, 4'd2, 1'b0, 1'b0);
    // One-cycle settle: every bit wrong.
    sweep(1'b1, 2'd0, 8'h0F, 8'hF0, 4'd8, 1'b0, 1'b0);
    sweep(1'b1, 2'd1, 8'h11, 8'h11, 4'd0, 1'b1, 1'b0);

    // Starts at cycle 5 and in the done cycle are ignored; start at 34 accepted.
    sel = 1'b0; mode = 2'd0; exp_r = 8'hF0;
    @(posedge clk); #1;
    accept();
    follow(4, 1'b1);
    check_results(8'hF0, 4'd0, 1'b1, 1'b0);
    post_done(8'hF0);
    mode = 2'd1; exp_r = 8'h11;
    accept();
    check("clear_observed", 32'(m_obs), 32'd0);
    check("clear_mcnt", 32'(m_mcnt), 32'd0);
    check("clear_pass", 32'(m_pass), 32'd0);
    check("restart_busy", 32'(m_busy), 32'd1);
    follow(4, 1'b0);
    check_results(8'h11, 4'd0, 1'b1, 1'b0);
    post_done(8'h11);

    // Reset at cycle 12 aborts the sweep with no done pulse.
    mode = 2'd0; exp_r = 8'hF0;
    accept();
    repeat (11) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(m_busy), 32'd0);
    check("abort_dut_in", 32'(m_dut_in), 32'd0);
    check("abort_done", 32'(m_done), 32'd0);
    check("abort_observed", 32'(m_obs), 32'd0);
    check("abort_mcnt", 32'(m_mcnt), 32'd0);
    check("abort_pass", 32'(m_pass), 32'd0);
    saw = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (m_done || m_busy) saw = 1;
    end
    check("abort_stays_idle", 32'(saw), 32'd0);
    sweep(1'b0, 2'd0, 8'hF0, 8'hF0, 4'd0, 1'b1, 1'b0);

`ifdef TT_STABILITY_CHECK_EN
    // Output flips only on the sampling cycle of vector 3: table matches but unstable.
    sweep(1'b0, 2'd2, 8'hF8, 8'hF8, 4'd0, 1'b0, 1'b1);
    // A clean sweep clears the sticky flag.
    sweep(1'b0, 2'd0, 8'hF0, 8'hF0, 4'd0, 1'b1, 1'b0);
    // One-cycle settle never flags instability.
    sweep(1'b1, 2'd1, 8'h11, 8'h11, 4'd0, 1'b1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
